// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit: one request at a time from execute, drives the data SRAM strobes
// from latched request fields, and returns load data or an exception code to writeback.
module ysyx_22041412_lsu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [2:0]            in_func3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [4:0]            out_rd,
    output logic [1:0]            out_exc,
    output logic [ADDR_WIDTH-1:0] sram_addr_r,
    output logic                  sram_read_en,
    output logic [2:0]            sram_func3,
    output logic [ADDR_WIDTH-1:0] sram_addr_w,
    output logic                  sram_wead_en,
    output logic [DATA_WIDTH-1:0] sram_data_w,
    input  logic [DATA_WIDTH-1:0] sram_data_r
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd2;

    state_t                state;
    logic                  op_load;
    logic                  op_store;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  illegal;
    logic                  misaligned;

    // Request checks only feed registers, so nothing from in_* reaches an output combinationally.
    always_comb begin
        illegal = (in_load == in_store)
                || (in_load && (in_func3 == 3'b111))
                || (in_store && in_func3[2]);
        case (in_func3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            default: misaligned = |in_addr[2:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_load   <= 1'b0;
            op_store  <= 1'b0;
            func3_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_exc   <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_load   <= in_load;
                        op_store  <= in_store;
                        func3_q   <= in_func3;
                        addr_q    <= in_addr;
                        wdata_q   <= in_wdata;
                        out_rd    <= in_rd;
                        out_rdata <= '0;
                        if (illegal) begin
                            out_exc   <= EXC_ILLEGAL;
                            out_valid <= 1'b1;
                            state     <= RESP;
                        end else if (misaligned) begin
                            out_exc   <= EXC_MISALIGN;
                            out_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            out_exc <= EXC_NONE;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (op_load) begin
                        state <= WAIT;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WAIT: begin
                    out_rdata <= sram_data_r;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state, so an async reset drops an in-flight write immediately.
    assign in_ready     = (state == IDLE);
    assign sram_read_en = (state == REQ) && op_load;
    assign sram_wead_en = (state == REQ) && op_store;
    assign sram_addr_r  = addr_q;
    assign sram_addr_w  = addr_q;
    assign sram_func3   = func3_q;
    assign sram_data_w  = wdata_q;

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Directed bench for the load/store unit with a small extending SRAM model.
module tb_ysyx_22041412_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_func3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic [1:0]  out_exc;
    logic [63:0] sram_addr_r;
    logic        sram_read_en;
    logic [2:0]  sram_func3;
    logic [63:0] sram_addr_w;
    logic        sram_wead_en;
    logic [63:0] sram_data_w;
    logic [63:0] sram_data_r;

    logic [63:0] mem_word;
    int          checks = 0;
    int          errors = 0;
    int          rd_strobes = 0;
    int          wr_strobes = 0;
    logic [63:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;
    logic [2:0]  last_wf3 = '0;

    ysyx_22041412_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_exc(out_exc),
        .sram_addr_r(sram_addr_r), .sram_read_en(sram_read_en), .sram_func3(sram_func3),
        .sram_addr_w(sram_addr_w), .sram_wead_en(sram_wead_en), .sram_data_w(sram_data_w),
        .sram_data_r(sram_data_r)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ext(input logic [63:0] w, input logic [2:0] f);
        case (f)
            3'd0:    return {{56{w[7]}}, w[7:0]};
            3'd1:    return {{48{w[15]}}, w[15:0]};
            3'd2:    return {{32{w[31]}}, w[31:0]};
            3'd3:    return w;
            3'd4:    return {56'b0, w[7:0]};
            3'd5:    return {48'b0, w[15:0]};
            3'd6:    return {32'b0, w[31:0]};
            default: return 64'b0;
        endcase
    endfunction

    always_comb sram_data_r = ext(mem_word, sram_func3);

    // Strobes are counted at the edge where the SRAM would sample them.
    always @(posedge clk) begin
        if (sram_read_en) rd_strobes <= rd_strobes + 1;
        if (sram_wead_en) begin
            wr_strobes <= wr_strobes + 1;
            last_waddr <= sram_addr_w;
            last_wdata <= sram_data_w;
            last_wf3   <= sram_func3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        in_valid = 1'b1;
        in_load  = ld;
        in_store = st;
        in_func3 = f3;
        in_addr  = addr;
        in_wdata = wdata;
        in_rd    = rd;
        tick();
        in_valid = 1'b0;
        in_load  = 1'b0;
        in_store = 1'b0;
    endtask

    task automatic runTxn(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                          input int exp_lat, input logic [63:0] exp_rdata, input logic [1:0] exp_exc,
                          input int exp_rds, input int exp_wrs);
        int r0, w0, lat;
        r0 = rd_strobes;
        w0 = wr_strobes;
        out_ready = 1'b1;
        applyStimulus(ld, st, f3, addr, wdata, rd);
        lat = 0;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " rdata"}, out_rdata, exp_rdata);
        checkOutput({tag, " rd"}, 64'(out_rd), 64'(rd));
        checkOutput({tag, " exc"}, 64'(out_exc), 64'(exp_exc));
        checkOutput({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
        tick();
        checkOutput({tag, " valid drop"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        checkOutput({tag, " read strobes"}, 64'(rd_strobes - r0), 64'(exp_rds));
        checkOutput({tag, " write strobes"}, 64'(wr_strobes - w0), 64'(exp_wrs));
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_func3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
        out_ready = 1'b0;
        mem_word = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_rdata", out_rdata, 64'd0);
        checkOutput("reset out_exc", 64'(out_exc), 64'd0);
        checkOutput("reset strobes", 64'({sram_read_en, sram_wead_en}), 64'd0);
        checkOutput("reset sram_addr_w", sram_addr_w, 64'd0);

        // lw with step-by-step strobe and stability checks
        mem_word = 64'h0000_0000_FFFF_8000;
        out_ready = 1'b1;
        w0 = rd_strobes;
        applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_0010, 64'd0, 5'd7);
        checkOutput("lw read_en E0", 64'(sram_read_en), 64'd1);
        checkOutput("lw wead_en E0", 64'(sram_wead_en), 64'd0);
        checkOutput("lw func3 E0", 64'(sram_func3), 64'd2);
        checkOutput("lw addr_r E0", sram_addr_r, 64'h8000_0010);
        checkOutput("lw out_valid E0", 64'(out_valid), 64'd0);
        tick();
        checkOutput("lw read_en E1", 64'(sram_read_en), 64'd0);
        checkOutput("lw func3 E1", 64'(sram_func3), 64'd2);
        checkOutput("lw out_valid E1", 64'(out_valid), 64'd0);
        tick();
        checkOutput("lw out_valid E2", 64'(out_valid), 64'd1);
        checkOutput("lw rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8000);
        checkOutput("lw rd", 64'(out_rd), 64'd7);
        checkOutput("lw exc", 64'(out_exc), 64'd0);
        tick();
        checkOutput("lw done", 64'(out_valid), 64'd0);
        checkOutput("lw read count", 64'(rd_strobes - w0), 64'd1);

        runTxn("sd", 1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd3,
               1, 64'd0, 2'd0, 0, 1);
        checkOutput("sd waddr", last_waddr, 64'h8000_0008);
        checkOutput("sd wdata", last_wdata, 64'h1122_3344_5566_7788);
        checkOutput("sd wfunc3", 64'(last_wf3), 64'd3);

        runTxn("lh misaligned", 1'b1, 1'b0, 3'b001, 64'h8000_0003, 64'd0, 5'd1, 0, 64'd0, 2'd1, 0, 0);
        runTxn("sw misaligned", 1'b0, 1'b1, 3'b010, 64'h8000_0006, 64'h55, 5'd2, 0, 64'd0, 2'd1, 0, 0);
        mem_word = 64'h0000_0000_0000_0080;
        runTxn("lbu", 1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 5'd4, 2, 64'h80, 2'd0, 1, 0);
        runTxn("lb", 1'b1, 1'b0, 3'b000, 64'h8000_0005, 64'd0, 5'd5, 2, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1, 0);
        runTxn("load f3=7", 1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'd0, 5'd6, 0, 64'd0, 2'd2, 0, 0);
        runTxn("store f3=4", 1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'd1, 5'd8, 0, 64'd0, 2'd2, 0, 0);
        runTxn("both ops", 1'b1, 1'b1, 3'b010, 64'h8000_0000, 64'd1, 5'd10, 0, 64'd0, 2'd2, 0, 0);
        runTxn("no op", 1'b0, 1'b0, 3'b010, 64'h8000_0000, 64'd1, 5'd12, 0, 64'd0, 2'd2, 0, 0);
        runTxn("illegal over misalign", 1'b0, 1'b1, 3'b101, 64'h8000_0001, 64'd1, 5'd13, 0, 64'd0, 2'd2, 0, 0);

        // Backpressure: response must hold while a new request waits at the input
        mem_word = 64'h0123_4567_89AB_CDEF;
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'd0, 5'd9);
        tick();
        tick();
        checkOutput("bp valid", 64'(out_valid), 64'd1);
        mem_word = 64'd0;
        in_valid = 1'b1; in_store = 1'b1; in_func3 = 3'b011;
        in_addr = 64'h8000_0040; in_wdata = 64'hAABB_CCDD_EEFF_0011; in_rd = 5'd11;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp hold valid", 64'(out_valid), 64'd1);
            checkOutput("bp hold rdata", out_rdata, 64'h0123_4567_89AB_CDEF);
            checkOutput("bp hold rd", 64'(out_rd), 64'd9);
            checkOutput("bp hold exc", 64'(out_exc), 64'd0);
            checkOutput("bp in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp no write", 64'(sram_wead_en), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp handshake valid", 64'(out_valid), 64'd0);
        checkOutput("bp handshake in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp not yet accepted", 64'(sram_wead_en), 64'd0);
        tick();
        in_valid = 1'b0; in_store = 1'b0;
        checkOutput("bp accepted wead_en", 64'(sram_wead_en), 64'd1);
        checkOutput("bp accepted addr_w", sram_addr_w, 64'h8000_0040);
        tick();
        checkOutput("bp store valid", 64'(out_valid), 64'd1);
        checkOutput("bp store rd", 64'(out_rd), 64'd11);
        checkOutput("bp store rdata", out_rdata, 64'd0);
        tick();
        checkOutput("bp store done", 64'(out_valid), 64'd0);

        // Asynchronous reset while a store strobe is high
        w0 = wr_strobes;
        applyStimulus(1'b0, 1'b1, 3'b010, 64'h8000_0010, 64'hDEAD_BEEF, 5'd4);
        checkOutput("rst pre wead_en", 64'(sram_wead_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst wead_en", 64'(sram_wead_en), 64'd0);
        checkOutput("rst out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst addr_w", sram_addr_w, 64'd0);
        checkOutput("rst data_w", sram_data_w, 64'd0);
        checkOutput("rst out_rd", 64'(out_rd), 64'd0);
        tick();
        checkOutput("rst dropped write", 64'(wr_strobes - w0), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("post rst in_ready", 64'(in_ready), 64'd1);
        checkOutput("post rst out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
